bus_xfer_engine: RTL and testbench

Parametrised successor to the single-bus mini-SRC datapath. It keeps a GP register file and the Y/Z/MAR/MDR staging registers around one internal bus. A built-in micro-sequencer runs whole register-transfer commands itself, so an external controller no longer drives per-cycle strobes. The fixed single-cycle RAM coupling is replaced by a req/ack memory handshake with arbitrary wait states.

---
 rtl/bus_xfer_pkg.sv | 35 +++
 rtl/bus_xfer_regfile.sv | 47 ++++
 rtl/bus_xfer_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_bus_xfer_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_pkg.sv
// bus_xfer_pkg: shared types for the bus transfer engine.
//   op_e    - command opcodes carried on cmd_op
//   state_e - micro-sequencer states; each state is one bus cycle
//   rw()    - register-select width for a given register count
package bus_xfer_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_MOV = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_LD  = 3'd4,
    OP_ST  = 3'd5,
    OP_LDI = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_XFER,
    S_YLD,
    S_ZCALC,
    S_WB,
    S_MAR,
    S_MDR,
    S_MEMRD,
    S_MEMWR,
    S_MDRWB
  } state_e;

  function automatic int rw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_xfer_regfile.sv
// bus_xfer_regfile: NUM_REGS x DATA_W general-purpose register file.
// Ports:
//   clk, clr                 - clock, asynchronous active-low reset (clears all)
//   ra_sel/ra_data           - combinational read port A
//   rb_sel/rb_data           - combinational read port B
//   dbg_sel/dbg_data         - combinational debug read port
//   wr_en, wr_sel, wr_data   - synchronous write port
// With ZERO_R0 != 0, register 0 reads as zero on every port and writes to it
// are discarded.
module bus_xfer_regfile
  import bus_xfer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ZERO_R0  = 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [rw(NUM_REGS)-1:0]   ra_sel,
  input  logic [rw(NUM_REGS)-1:0]   rb_sel,
  input  logic [rw(NUM_REGS)-1:0]   dbg_sel,
  output logic [DATA_W-1:0]         ra_data,
  output logic [DATA_W-1:0]         rb_data,
  output logic [DATA_W-1:0]         dbg_data,
  input  logic                      wr_en,
  input  logic [rw(NUM_REGS)-1:0]   wr_sel,
  input  logic [DATA_W-1:0]         wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = wr_en && !((ZERO_R0 != 0) && (wr_sel == '0));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_sel] <= wr_data;
    end
  end

  assign ra_data  = ((ZERO_R0 != 0) && (ra_sel  == '0)) ? '0 : regs[ra_sel];
  assign rb_data  = ((ZERO_R0 != 0) && (rb_sel  == '0)) ? '0 : regs[rb_sel];
  assign dbg_data = ((ZERO_R0 != 0) && (dbg_sel == '0)) ? '0 : regs[dbg_sel];

endmodule

// File: rtl/bus_xfer_engine.sv
// bus_xfer_engine: single-bus register-transfer datapath with a built-in
// micro-sequencer and a req/ack memory port.
// Ports:
//   clk, clr            - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready - command handshake; cmd_op/rd/ra/rb/imm are the fields
//   mem_req/we/addr/wdata, mem_rdata/mem_ack - memory request/acknowledge port
//   done                - one-cycle pulse in the final cycle of each command
//   carry               - carry of last ADD / borrow of last SUB
//   err                 - sticky memory timeout flag
//   bus_mon             - internal bus value (0 when undriven)
//   dbg_sel/dbg_data    - combinational register read-back
//   dbg_state           - current sequencer state
// Optional feature: define BUS_XFER_TIMEOUT_EN to abort a memory access that
// sees no mem_ack within TIMEOUT cycles; otherwise the engine waits forever and
// err is constant 0.
//
// Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready;
// cmd_ready is high only while idle. A memory access holds mem_req, mem_we,
// mem_addr and mem_wdata steady from the first request cycle through the cycle
// mem_ack is seen, and mem_req drops on the following cycle; mem_ack in any
// other cycle is ignored.
module bus_xfer_engine
  import bus_xfer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 16,
  parameter int IMM_W    = 16,
  parameter int ZERO_R0  = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [rw(NUM_REGS)-1:0] cmd_rd,
  input  logic [rw(NUM_REGS)-1:0] cmd_ra,
  input  logic [rw(NUM_REGS)-1:0] cmd_rb,
  input  logic [IMM_W-1:0]        cmd_imm,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic                    done,
  output logic                    carry,
  output logic                    err,
  output logic [DATA_W-1:0]       bus_mon,
  input  logic [rw(NUM_REGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]       dbg_data,
  output logic [3:0]              dbg_state
);

  localparam int RW = rw(NUM_REGS);

  state_e            state;
  op_e               op_q;
  logic [RW-1:0]     rd_q, ra_q, rb_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] y, z, mdr;
  logic [ADDR_W-1:0] mar;

  logic [DATA_W-1:0] bus, ra_data, rb_data, imm_ext;
  logic [DATA_W:0]   alu;
  logic              wr_en, mem_busy, tmo_hit;

  bus_xfer_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ZERO_R0 (ZERO_R0)
  ) u_regfile (
    .clk     (clk),
    .clr     (clr),
    .ra_sel  (ra_q),
    .rb_sel  (rb_q),
    .dbg_sel (dbg_sel),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .dbg_data(dbg_data),
    .wr_en   (wr_en),
    .wr_sel  (rd_q),
    .wr_data (bus)
  );

  assign imm_ext = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  // One source drives the bus per state; undriven cycles read as zero.
  always_comb begin
    bus = '0;
    case (state)
      S_XFER: begin
        if (op_q == OP_MOV)      bus = ra_data;
        else if (op_q == OP_LDI) bus = imm_ext;
      end
      S_YLD, S_MAR:   bus = ra_data;
      S_ZCALC, S_MDR: bus = rb_data;
      S_WB:           bus = z;
      S_MDRWB:        bus = mdr;
      default:        bus = '0;
    endcase
  end

  // The extra top bit is the carry for ADD and the borrow for SUB.
  assign alu = (op_q == OP_SUB) ? ({1'b0, y} - {1'b0, bus})
                                : ({1'b0, y} + {1'b0, bus});

  assign wr_en = ((state == S_XFER) && ((op_q == OP_MOV) || (op_q == OP_LDI)))
              || (state == S_WB) || (state == S_MDRWB);

  assign mem_busy = (state == S_MEMRD) || (state == S_MEMWR);

  // done must coincide with the ack cycle of a store, so it is decoded here
  // rather than registered.
  assign done = (state == S_XFER) || (state == S_WB) || (state == S_MDRWB)
             || ((state == S_MEMWR) && mem_ack) || tmo_hit;

  assign cmd_ready = (state == S_IDLE);
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign bus_mon   = bus;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= S_IDLE;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
      y       <= '0;
      z       <= '0;
      mar     <= '0;
      mdr     <= '0;
      carry   <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= op_e'(cmd_op);
            rd_q  <= cmd_rd;
            ra_q  <= cmd_ra;
            rb_q  <= cmd_rb;
            imm_q <= cmd_imm;
            case (op_e'(cmd_op))
              OP_ADD, OP_SUB: state <= S_YLD;
              OP_LD, OP_ST:   state <= S_MAR;
              default:        state <= S_XFER;
            endcase
          end
        end
        S_XFER: state <= S_IDLE;
        S_YLD: begin
          y     <= bus;
          state <= S_ZCALC;
        end
        S_ZCALC: begin
          z     <= alu[DATA_W-1:0];
          carry <= alu[DATA_W];
          state <= S_WB;
        end
        S_WB: state <= S_IDLE;
        S_MAR: begin
          mar <= bus[ADDR_W-1:0];
          if (op_q == OP_LD) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            state   <= S_MEMRD;
          end else begin
            state <= S_MDR;
          end
        end
        S_MDR: begin
          mdr     <= bus;
          mem_req <= 1'b1;
          mem_we  <= 1'b1;
          state   <= S_MEMWR;
        end
        S_MEMRD: begin
          if (mem_ack) begin
            mdr     <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_MDRWB;
          end else if (tmo_hit) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_MEMWR: begin
          if (mem_ack || tmo_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_MDRWB: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BUS_XFER_TIMEOUT_EN
  localparam int TMO_BITS = $clog2(TIMEOUT + 1);
  localparam int TMO_W    = (TMO_BITS > 8) ? TMO_BITS : 8;

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // tmo_cnt counts completed wait cycles; the abort fires in the TIMEOUT-th
  // request cycle if that cycle also has no ack.
  assign tmo_hit = mem_busy && !mem_ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= mem_busy ? (tmo_cnt + 1'b1) : '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  logic        unused_busy;
  assign unused_timeout = TIMEOUT;
  assign unused_busy    = mem_busy;
  assign tmo_hit        = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_bus_xfer_engine.sv
// tb_bus_xfer_engine: self-checking bench for bus_xfer_engine.
// A per-command timing/result model builds one expected record per clock
// cycle; a compare process checks the DUT against each record at the falling
// edge. Directed commands pin the model with literal values, then random
// commands with random wait states, stray mem_ack and stray cmd_valid follow.
// Define BUS_XFER_TIMEOUT_EN to also exercise the memory timeout (TIMEOUT=4).
module tb_bus_xfer_engine;

  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int AW  = 16;
  localparam int IW  = 16;
  localparam int RW  = 4;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [RW-1:0] cmd_rd, cmd_ra, cmd_rb, dbg_sel;
  logic [IW-1:0] cmd_imm;
  logic          mem_req, mem_we, mem_ack, done, carry, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, bus_mon, dbg_data;
  logic [3:0]    unused_state;

  bus_xfer_engine #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .IMM_W(IW), .ZERO_R0(1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .done(done), .carry(carry), .err(err), .bus_mon(bus_mon),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(unused_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  typedef struct {
    logic          ready, done, req, we, carry, err, bus_chk;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, bus, dbg;
    logic [RW-1:0] sel;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          ce;
  logic [DW-1:0] m_regs [NR];
  logic          m_carry, m_err;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rreg(input logic [RW-1:0] i);
    return (i == '0) ? '0 : m_regs[i];
  endfunction

  task automatic set_reg(input logic [RW-1:0] i, input logic [DW-1:0] v);
    if (i != '0) m_regs[i] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_carry = 1'b0;
    m_err   = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk1("cmd_ready", cmd_ready, ce.ready);
      chk1("done", done, ce.done);
      chk1("mem_req", mem_req, ce.req);
      if (ce.req) begin
        chk1("mem_we", mem_we, ce.we);
        chk32("mem_addr", 32'(mem_addr), 32'(ce.addr));
        if (ce.we) chk32("mem_wdata", mem_wdata, ce.wdata);
      end
      chk1("carry", carry, ce.carry);
      chk1("err", err, ce.err);
      chk32("dbg_data", dbg_data, ce.dbg);
      if (ce.bus_chk) chk32("bus_mon", bus_mon, ce.bus);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs for the current cycle are already set; record what the outputs must
  // be in this cycle, then advance to just after the next rising edge.
  task automatic cyc(input logic d, input logic rq, input logic we,
                     input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic bchk, input logic [DW-1:0] b, input logic rdy);
    exp_t e;
    dbg_sel   = RW'($urandom_range(0, NR-1));
    e.ready   = rdy;
    e.done    = d;
    e.req     = rq;
    e.we      = we;
    e.addr    = a;
    e.wdata   = wd;
    e.bus_chk = bchk;
    e.bus     = b;
    e.sel     = dbg_sel;
    e.dbg     = rreg(dbg_sel);
    e.carry   = m_carry;
    e.err     = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Noise that the engine must ignore while busy / outside memory states.
  task automatic junk();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_rd    = RW'($urandom_range(0, NR-1));
    cmd_ra    = RW'($urandom_range(0, NR-1));
    cmd_rb    = RW'($urandom_range(0, NR-1));
    cmd_imm   = IW'($urandom_range(0, 65535));
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      junk();
      cmd_valid = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b1);
    end
  endtask

  // w = number of wait cycles before ack; w < 0 means never ack.
  task automatic run_cmd(input logic [2:0] op, input logic [RW-1:0] rd,
                         input logic [RW-1:0] ra, input logic [RW-1:0] rb,
                         input logic [IW-1:0] imm, input int w,
                         input logic [DW-1:0] rdv);
    logic [DW-1:0] a, b, res;
    logic [DW:0]   wide;
    logic [AW-1:0] ad;
    logic          cy, tmo, ak;
    a  = rreg(ra);
    b  = rreg(rb);
    ad = a[AW-1:0];
    junk();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_ra    = ra;
    cmd_rb    = rb;
    cmd_imm   = imm;
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b1);
    case (op)
      3'd1: begin
        junk(); cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, a, 1'b0);
        set_reg(rd, a);
      end
      3'd6: begin
        res = {{(DW-IW){imm[IW-1]}}, imm};
        junk(); cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, res, 1'b0);
        set_reg(rd, res);
      end
      3'd2, 3'd3: begin
        if (op == 3'd2) begin
          wide = {1'b0, a} + {1'b0, b};
          res  = wide[DW-1:0];
          cy   = wide[DW];
        end else begin
          res = a - b;
          cy  = (a < b);
        end
        junk(); cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        junk(); cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        m_carry = cy;
        junk(); cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, res, 1'b0);
        set_reg(rd, res);
      end
      3'd4: begin
        junk(); cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < TMO; i++) begin
          junk();
          ak      = (i == w);
          mem_ack = ak;
          if (ak) mem_rdata = rdv;
          tmo = (w < 0) && (i == TMO - 1);
          cyc(tmo, 1'b1, 1'b0, ad, '0, 1'b0, '0, 1'b0);
          if (ak) break;
        end
        if (w < 0) begin
          m_err = 1'b1;
        end else begin
          junk(); cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, rdv, 1'b0);
          set_reg(rd, rdv);
        end
      end
      3'd5: begin
        junk(); cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        junk(); cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < TMO; i++) begin
          junk();
          ak      = (i == w);
          mem_ack = ak;
          tmo     = (w < 0) && (i == TMO - 1);
          cyc(ak || tmo, 1'b1, 1'b1, ad, b, 1'b0, '0, 1'b0);
          if (ak) break;
        end
        if (w < 0) m_err = 1'b1;
      end
      default: begin
        junk(); cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b0);
      end
    endcase
  endtask

  // Literal read-back in an idle cycle (no model record for this cycle).
  task automatic lit_reg(input logic [RW-1:0] sel, input logic [DW-1:0] v, input string name);
    cmd_valid = 1'b0;
    mem_ack   = 1'b0;
    dbg_sel   = sel;
    #1;
    chk32(name, dbg_data, v);
    chk1({name, "_ready"}, cmd_ready, 1'b1);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_imm = '0; mem_ack = 1'b0; mem_rdata = '0; dbg_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    chk1("rst_ready", cmd_ready, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk1("rst_carry", carry, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk32("rst_bus", bus_mon, '0);
    for (int i = 0; i < NR; i++) begin
      dbg_sel = RW'(i);
      #0.1;
      chk32("rst_reg", dbg_data, '0);
    end
    next_edge();

    // Directed commands with literal expectations.
    run_cmd(3'd6, 4'd3, 4'd0, 4'd0, 16'hFFFE, 0, '0);
    lit_reg(4'd3, 32'hFFFF_FFFE, "ldi_sext");
    next_edge();
    run_cmd(3'd6, 4'd1, 4'd0, 4'd0, 16'd5, 0, '0);
    run_cmd(3'd6, 4'd2, 4'd0, 4'd0, 16'd7, 0, '0);
    run_cmd(3'd2, 4'd4, 4'd1, 4'd2, '0, 0, '0);
    lit_reg(4'd4, 32'd12, "add_r4");
    chk1("add_carry", carry, 1'b0);
    next_edge();
    run_cmd(3'd3, 4'd5, 4'd1, 4'd2, '0, 0, '0);
    lit_reg(4'd5, 32'hFFFF_FFFE, "sub_r5");
    chk1("sub_borrow", carry, 1'b1);
    next_edge();
    run_cmd(3'd6, 4'd6, 4'd0, 4'd0, 16'h0100, 0, '0);
    run_cmd(3'd5, 4'd0, 4'd6, 4'd1, '0, 3, '0);
    run_cmd(3'd4, 4'd7, 4'd6, 4'd0, '0, 0, 32'hDEAD_BEEF);
    lit_reg(4'd7, 32'hDEAD_BEEF, "ld_r7");
    next_edge();
    run_cmd(3'd1, 4'd0, 4'd4, 4'd0, '0, 0, '0);
    lit_reg(4'd0, '0, "mov_r0");
    next_edge();
    run_cmd(3'd6, 4'd8, 4'd0, 4'd0, 16'h0055, 0, '0);
    run_cmd(3'd1, 4'd8, 4'd0, 4'd0, '0, 0, '0);
    lit_reg(4'd8, '0, "mov_from_r0");
    next_edge();
    run_cmd(3'd1, 4'd9, 4'd9, 4'd0, '0, 0, '0);
    idle(2);

    // Reset while a load waits for memory.
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_rd = 4'd7; cmd_ra = 4'd6; mem_ack = 1'b0;
    next_edge();
    cmd_valid = 1'b0;
    next_edge();
    chk1("rst_mid_req_before", mem_req, 1'b1);
    #1;
    clr = 1'b0;
    #1;
    chk1("rst_mid_req_drop", mem_req, 1'b0);
    chk1("rst_mid_no_done", done, 1'b0);
    chk1("rst_mid_carry", carry, 1'b0);
    for (int i = 0; i < NR; i++) begin
      dbg_sel = RW'(i);
      #0.1;
      chk32("rst_mid_reg", dbg_data, '0);
    end
    next_edge();
    clr = 1'b1;
    model_reset();
    idle(3);

`ifdef BUS_XFER_TIMEOUT_EN
    run_cmd(3'd6, 4'd9, 4'd0, 4'd0, 16'h1234, 0, '0);
    run_cmd(3'd6, 4'd6, 4'd0, 4'd0, 16'h0200, 0, '0);
    run_cmd(3'd4, 4'd9, 4'd6, 4'd0, '0, -1, 32'hCAFE_F00D);
    lit_reg(4'd9, 32'h0000_1234, "tmo_rd_kept");
    chk1("tmo_err", err, 1'b1);
    next_edge();
    run_cmd(3'd5, 4'd0, 4'd6, 4'd9, '0, -1, '0);
    idle(1);
`endif

    // Randomised commands.
    for (int k = 0; k < 300; k++) begin
      run_cmd(3'($urandom_range(0, 7)), RW'($urandom_range(0, NR-1)),
              RW'($urandom_range(0, NR-1)), RW'($urandom_range(0, NR-1)),
              IW'($urandom_range(0, 65535)), $urandom_range(0, 3), $urandom);
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
